// File: rtl/npu_stream_loader.sv
// npu_stream_loader: streams an image then a kernel tensor from byte memory as two AXI-Stream packets
module npu_stream_loader #(
    parameter int ADDR_WIDTH         = 13,
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_CHANNELS_WIDTH = 7,
    parameter int MEM_ADDR_WIDTH     = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [MEM_ADDR_WIDTH-1:0]                    img_base,
    input  logic [MEM_ADDR_WIDTH-1:0]                    img_len,
    input  logic [MEM_ADDR_WIDTH-1:0]                    ker_base,
    input  logic [MEM_ADDR_WIDTH-1:0]                    ker_len,
    input  logic [ADDR_WIDTH-1:0]                        img_row,
    input  logic [ADDR_WIDTH-1:0]                        img_col,
    input  logic [ADDR_WIDTH-1:0]                        ker_row,
    input  logic [ADDR_WIDTH-1:0]                        ker_col,
    input  logic [NUM_CHANNELS_WIDTH-1:0]                num_channels,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         mem_en,
    output logic [MEM_ADDR_WIDTH-1:0]                    mem_addr,
    input  logic [DATA_WIDTH-1:0]                        mem_rdata,
    output logic [DATA_WIDTH-1:0]                        m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]                      m_axis_tstrb,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic                                         m_axis_tlast,
    output logic [4*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1:0]   m_axis_tuser
);
    localparam int MA  = MEM_ADDR_WIDTH;
    localparam int TUW = 4*ADDR_WIDTH+NUM_CHANNELS_WIDTH;

    typedef enum logic [1:0] {IDLE, IMG, KER, FIN} state_t;
    state_t state, state_nx;

    logic [MA-1:0]         img_base_q, img_len_q, ker_base_q, ker_len_q;
    logic [MA-1:0]         b_img, l_img, b_ker, l_ker;
    logic [TUW-1:0]        tuser_q;
    logic [MA:0]           issued, idx, idx_inc, tot;
    logic                  start_acc, active, rd_pend, pend_last, rd_last, pop, wr_lo;
    logic [1:0]            cnt, occ;
    logic [DATA_WIDTH-1:0] d0, d1;
    logic                  l0, l1;

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !start ? IDLE : img_len != '0 ? IMG : ker_len != '0 ? KER : FIN;
            IMG:     state_nx = !(pop && l0) ? IMG : ker_len_q != '0 ? KER : FIN;
            KER:     state_nx = (pop && l0) ? FIN : KER;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state == IMG || state == KER;
        done = state == FIN;
    end

    // The whole transfer is one linear byte sequence: image bytes, then kernel bytes.
    // The first read issues in the start cycle, using the live inputs, to reach 2-cycle latency.
    always_comb begin
        start_acc = state == IDLE && start;
        b_img     = start_acc ? img_base : img_base_q;
        l_img     = start_acc ? img_len  : img_len_q;
        b_ker     = start_acc ? ker_base : ker_base_q;
        l_ker     = start_acc ? ker_len  : ker_len_q;
        tot       = {1'b0, l_img} + {1'b0, l_ker};
        idx       = state == IDLE ? '0 : issued;
        idx_inc   = idx + {{MA{1'b0}}, 1'b1};
        pop       = m_axis_tvalid && m_axis_tready;
        occ       = cnt - {1'b0, pop} + {1'b0, rd_pend};
        wr_lo     = (cnt - {1'b0, pop}) == 2'd0;
        active    = start_acc || busy;
        mem_en    = active && idx < tot && occ < 2'd2;
        mem_addr  = !mem_en ? '0 : idx < {1'b0, l_img} ? b_img + idx[MA-1:0] : b_ker + idx[MA-1:0] - l_img;
        rd_last   = idx_inc == {1'b0, l_img} || idx_inc == tot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            img_base_q <= '0;
            img_len_q  <= '0;
            ker_base_q <= '0;
            ker_len_q  <= '0;
            tuser_q    <= '0;
            issued     <= '0;
            rd_pend    <= 1'b0;
            pend_last  <= 1'b0;
            cnt        <= '0;
            d0         <= '0;
            d1         <= '0;
            l0         <= 1'b0;
            l1         <= 1'b0;
        end else begin
            if (start_acc) begin
                img_base_q <= img_base;
                img_len_q  <= img_len;
                ker_base_q <= ker_base;
                ker_len_q  <= ker_len;
                tuser_q    <= {num_channels, ker_col, ker_row, img_col, img_row};
            end
            issued    <= idx + {{MA{1'b0}}, mem_en};
            rd_pend   <= mem_en;
            pend_last <= rd_last;
            cnt       <= occ;
            if (pop) begin
                d0 <= d1;
                l0 <= l1;
            end
            if (rd_pend && wr_lo) begin
                d0 <= mem_rdata;
                l0 <= pend_last;
            end
            if (rd_pend && !wr_lo) begin
                d1 <= mem_rdata;
                l1 <= pend_last;
            end
        end
    end

    always_comb begin
        m_axis_tvalid = cnt != 2'd0;
        m_axis_tdata  = d0;
        m_axis_tlast  = m_axis_tvalid && l0;
        m_axis_tstrb  = m_axis_tvalid ? '1 : '0;
        m_axis_tuser  = tuser_q;
    end
endmodule

// File: tb/tb_npu_stream_loader.sv
// tb_npu_stream_loader: scoreboard bench for npu_stream_loader against a byte-sequence reference model
module tb_npu_stream_loader;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] img_base, img_len, ker_base, ker_len;
    logic [12:0] img_row, img_col, ker_row, ker_col;
    logic [6:0]  num_channels;
    logic        busy, done, mem_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata, tdata;
    logic [0:0]  tstrb;
    logic        tvalid, tready, tlast;
    logic [58:0] tuser;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_d [$];
    logic        exp_l [$];
    logic [58:0] exp_u [$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, beats = 0, done_cnt = 0, done_base = 0, rd_cnt = 0;
    int done_cyc = 0, last_hs_cyc = 0, start_cyc = 0;
    int mode = 0;
    logic        prev_stall = 1'b0, prev_l;
    logic [7:0]  prev_d;
    logic [58:0] prev_u;

    npu_stream_loader dut (
        .clk(clk), .rst(rst), .start(start),
        .img_base(img_base), .img_len(img_len), .ker_base(ker_base), .ker_len(ker_len),
        .img_row(img_row), .img_col(img_col), .ker_row(ker_row), .ker_col(ker_col),
        .num_channels(num_channels), .busy(busy), .done(done),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .m_axis_tdata(tdata), .m_axis_tstrb(tstrb), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tuser(tuser)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) rd_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_all_beats_sent", 64'(exp_d.size()), 0);
            end
            if (prev_stall) begin
                check("stall_valid", tvalid, 1);
                check("stall_data", tdata, prev_d);
                check("stall_last", tlast, prev_l);
                check("stall_user", tuser, prev_u);
            end
            if (tvalid) check("tstrb", tstrb, 1);
            if (tvalid && tready) begin
                beats++;
                last_hs_cyc = cyc;
                check("beat_expected", exp_d.size() != 0, 1);
                if (exp_d.size() != 0) begin
                    check("beat_data", tdata, exp_d.pop_front());
                    check("beat_last", tlast, exp_l.pop_front());
                    check("beat_user", tuser, exp_u.pop_front());
                end
            end
            prev_stall = tvalid && !tready;
            prev_d = tdata;
            prev_l = tlast;
            prev_u = tuser;
        end else prev_stall = 1'b0;
    end

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = mode == 0 ? 1'b1 : mode == 1 ? ~tready : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic start_xfer(input logic [15:0] ib, il, kb, kl, input logic [12:0] ir, ic, kr, kc,
                              input logic [6:0] nc);
        logic [58:0] u;
        logic [15:0] a;
        u = {nc, kc, kr, ic, ir};
        for (int i = 0; i < int'(il); i++) begin
            a = 16'(ib + 16'(i));
            exp_d.push_back(mem[a]);
            exp_l.push_back(i == int'(il) - 1);
            exp_u.push_back(u);
        end
        for (int i = 0; i < int'(kl); i++) begin
            a = 16'(kb + 16'(i));
            exp_d.push_back(mem[a]);
            exp_l.push_back(i == int'(kl) - 1);
            exp_u.push_back(u);
        end
        img_base = ib; img_len = il; ker_base = kb; ker_len = kl;
        img_row = ir; img_col = ic; ker_row = kr; ker_col = kc; num_channels = nc;
        done_base = done_cnt;
        rd_cnt = 0;
        start_cyc = cyc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == done_base && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("done_within_budget", done_cnt != done_base, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, t;
        logic [15:0] il, kl;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mem[16'h10 + i] = 8'(i + 1);
        mem[16'h80] = 8'd9;
        mem[16'h81] = 8'd8;
        rst = 1'b1; start = 1'b0;
        img_base = '0; img_len = '0; ker_base = '0; ker_len = '0;
        img_row = '0; img_col = '0; ker_row = '0; ker_col = '0; num_channels = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_en", mem_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        mode = 0;
        start_xfer(16'h10, 16'd4, 16'h80, 16'd2, 13'd28, 13'd28, 13'd3, 13'd3, 7'd1);
        @(negedge clk);
        check("first_valid_c1", tvalid, 0);
        @(negedge clk);
        check("first_valid_c2", tvalid, 1);
        check("first_data", tdata, 8'd1);
        check("busy_during", busy, 1);
        wait_done();
        check("done_after_last", done_cyc, last_hs_cyc + 1);

        mode = 1;
        start_xfer(16'h10, 16'd4, 16'h80, 16'd2, 13'd28, 13'd28, 13'd3, 13'd3, 7'd1);
        wait_done();

        mode = 3;
        start_xfer(16'h10, 16'd4, 16'h80, 16'd2, 13'd5, 13'd6, 13'd7, 13'd8, 7'd9);
        repeat (20) @(posedge clk);
        #1;
        check("stall_reads_le2", rd_cnt <= 2, 1);
        check("stall_hold_valid", tvalid, 1);
        check("stall_hold_byte1", tdata, 8'd1);
        mode = 0;
        wait_done();

        start_xfer(16'h0, 16'd0, 16'h80, 16'd3, 13'd1, 13'd2, 13'd3, 13'd4, 7'd5);
        wait_done();

        b0 = beats;
        start_xfer(16'h0, 16'd0, 16'h0, 16'd0, 13'd1, 13'd2, 13'd3, 13'd4, 7'd5);
        wait_done();
        check("zero_len_done_cycle", done_cyc, start_cyc + 1);
        check("zero_len_no_beats", beats, b0);

        start_xfer(16'hFFFE, 16'd4, 16'hFFFF, 16'd3, 13'd11, 13'd12, 13'd2, 13'd2, 7'd64);
        wait_done();

        b0 = beats;
        start_xfer(16'h10, 16'd4, 16'h80, 16'd2, 13'd28, 13'd28, 13'd3, 13'd3, 7'd1);
        t = 0;
        while (beats < b0 + 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("reached_beat2", beats >= b0 + 2, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tvalid", tvalid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, done_base);
        check("abort_idle_valid", tvalid, 0);
        exp_d.delete(); exp_l.delete(); exp_u.delete();
        start_xfer(16'h10, 16'd4, 16'h80, 16'd2, 13'd28, 13'd28, 13'd3, 13'd3, 7'd1);
        wait_done();

        for (int r = 0; r < 14; r++) begin
            mode = int'($urandom_range(0, 2));
            il = $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom_range(1, 20));
            kl = $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom_range(1, 20));
            start_xfer(16'($urandom), il, 16'($urandom), kl, 13'($urandom), 13'($urandom),
                       13'($urandom), 13'($urandom), 7'($urandom));
            if (int'(il) + int'(kl) >= 8) begin
                repeat (2) @(posedge clk);
                #1;
                img_base = 16'($urandom); img_len = 16'd1; ker_len = 16'd1; img_row = 13'($urandom);
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
